// File: rtl/operand_streamer.sv
// Serial operand loader: holds one pixel's input/weight operands in local memories and
// streams them to the PE-array controller, then reports pixel/picture completion.
module operand_streamer #(
   parameter int WIDTH  = 8,
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int VECTOR = 4,
   parameter int PIXELS = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic             wr_sel_i,
   input  logic [7:0]       wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             go_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [7:0]       pixel_cnt_o,
   output logic             start_o,
   output logic [WIDTH-1:0] in_o,
   output logic [WIDTH-1:0] w_o,
   input  logic             loadin_finish_i,
   input  logic             cal_finish_i,
   output logic             pixel_finish_o,
   output logic             picture_finish_o
);

   localparam int IN_N = COLS * VECTOR;
   localparam int W_N  = ROWS * COLS;
   localparam int IAW  = (IN_N > 1) ? $clog2(IN_N) : 1;
   localparam int WAW  = (W_N > 1) ? $clog2(W_N) : 1;
   localparam int CW   = (IAW > WAW) ? IAW : WAW;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_SEND_IN  = 3'd2;
   localparam logic [2:0] S_WAIT_IN  = 3'd3;
   localparam logic [2:0] S_SEND_W   = 3'd4;
   localparam logic [2:0] S_WAIT_CAL = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             in_seen_q, in_seen_d;
   logic             cal_seen_q, cal_seen_d;
   logic [7:0]       pixel_cnt_q, pixel_cnt_d;
   logic             busy_q, done_q, start_q, pixel_finish_q, picture_finish_q;
   logic [WIDTH-1:0] in_q, w_q;

   logic [WIDTH-1:0] inmem [IN_N];
   logic [WIDTH-1:0] wmem  [W_N];

   logic in_we, w_we;

   // Host writes land only while idle so a running stream never sees a torn operand set.
   assign in_we = (state_q == S_IDLE) && wr_en_i && !wr_sel_i && (int'(wr_addr_i) < IN_N);
   assign w_we  = (state_q == S_IDLE) && wr_en_i &&  wr_sel_i && (int'(wr_addr_i) < W_N);

   always_ff @(posedge clk_i) begin
      if (in_we) inmem[wr_addr_i[IAW-1:0]] <= wr_data_i;
      if (w_we)  wmem[wr_addr_i[WAW-1:0]]  <= wr_data_i;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (go_i) state_d = S_START;
         end
         S_START: begin
            state_d = S_SEND_IN;
            idx_d   = '0;
         end
         S_SEND_IN: begin
            if (idx_q == CW'(IN_N - 1)) begin
               idx_d   = '0;
               state_d = in_seen_q ? S_SEND_W : S_WAIT_IN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_WAIT_IN: begin
            if (in_seen_q) begin
               state_d = S_SEND_W;
               idx_d   = '0;
            end
         end
         S_SEND_W: begin
            if (idx_q == CW'(W_N - 1)) begin
               idx_d   = '0;
               state_d = cal_seen_q ? S_DONE : S_WAIT_CAL;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_WAIT_CAL: begin
            if (cal_seen_q) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Handshake pulses may arrive early (even mid-stream), so they are latched until consumed.
   always_comb begin
      in_seen_d  = in_seen_q;
      cal_seen_d = cal_seen_q;
      if (state_q == S_START) begin
         in_seen_d  = 1'b0;
         cal_seen_d = 1'b0;
      end else if (state_q != S_IDLE) begin
         if (loadin_finish_i) in_seen_d  = 1'b1;
         if (cal_finish_i)    cal_seen_d = 1'b1;
      end
   end

   always_comb begin
      pixel_cnt_d = pixel_cnt_q;
      if (state_d == S_DONE) begin
         if (pixel_cnt_q == 8'(PIXELS - 1)) pixel_cnt_d = '0;
         else                               pixel_cnt_d = pixel_cnt_q + 8'd1;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= S_IDLE;
         idx_q            <= '0;
         in_seen_q        <= 1'b0;
         cal_seen_q       <= 1'b0;
         pixel_cnt_q      <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         start_q          <= 1'b0;
         pixel_finish_q   <= 1'b0;
         picture_finish_q <= 1'b0;
         in_q             <= '0;
         w_q              <= '0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         in_seen_q        <= in_seen_d;
         cal_seen_q       <= cal_seen_d;
         pixel_cnt_q      <= pixel_cnt_d;
         busy_q           <= (state_d != S_IDLE);
         done_q           <= (state_d == S_DONE);
         start_q          <= (state_d == S_START);
         pixel_finish_q   <= (state_d == S_DONE);
         picture_finish_q <= (state_d == S_DONE) && (pixel_cnt_q == 8'(PIXELS - 1));
         in_q             <= (state_d == S_SEND_IN) ? inmem[idx_d[IAW-1:0]] : '0;
         w_q              <= (state_d == S_SEND_W)  ? wmem[idx_d[WAW-1:0]]  : '0;
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign pixel_cnt_o      = pixel_cnt_q;
   assign start_o          = start_q;
   assign in_o             = in_q;
   assign w_o              = w_q;
   assign pixel_finish_o   = pixel_finish_q;
   assign picture_finish_o = picture_finish_q;

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: a table of pixel handshake scenarios with
// hand-computed timing, plus hand-written reset and go/rst collision sequences.
module tb_operand_streamer;

   logic       clk_i = 1'b0;
   logic       rst_i, wr_en_i, wr_sel_i, go_i, loadin_finish_i, cal_finish_i;
   logic [7:0] wr_addr_i, wr_data_i;
   logic       busy_o, done_o, start_o, pixel_finish_o, picture_finish_o;
   logic [7:0] pixel_cnt_o, in_o, w_o;

   operand_streamer dut (
      .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .go_i(go_i),
      .busy_o(busy_o), .done_o(done_o), .pixel_cnt_o(pixel_cnt_o), .start_o(start_o),
      .in_o(in_o), .w_o(w_o), .loadin_finish_i(loadin_finish_i),
      .cal_finish_i(cal_finish_i), .pixel_finish_o(pixel_finish_o),
      .picture_finish_o(picture_finish_o)
   );

   always #5 clk_i = ~clk_i;

   // lf/cf: edge (relative to go edge T) where the pulse is sampled; w0: first w byte;
   // dn: pixel_finish cycle; prot: go+write mid-stream; wrgo: write together with go.
   typedef struct {
      int lf; int cf; int w0; int dn; bit prot; bit wrgo;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] inm [16];
   logic [7:0] wm  [16];
   int         pix_m;
   int         errs, checks;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s @T+%0d: got %0h expected %0h", name, s, act, exp);
      end
   endtask

   task automatic wr(input logic sel, input logic [7:0] addr, input logic [7:0] data);
      wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
      tick;
      wr_en_i = 1'b0;
   endtask

   task automatic load_all;
      for (int i = 0; i < 16; i++) wr(1'b0, 8'(i), inm[i]);
      for (int i = 0; i < 16; i++) wr(1'b1, 8'(i), wm[i]);
   endtask

   task automatic run_pixel(input int k);
      vec_t e;
      bit   pic;
      e = tbl[k];
      pic = (pix_m == 3);
      go_i = 1'b1;
      if (e.wrgo) begin
         wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 8'd3; wr_data_i = 8'hA5;
         inm[3] = 8'hA5;
      end
      tick;
      go_i = 1'b0; wr_en_i = 1'b0;
      for (int s = 1; s <= e.dn + 1; s++) begin
         loadin_finish_i = (s == e.lf);
         cal_finish_i    = (s == e.cf);
         go_i            = e.prot && (s == 5);
         wr_en_i         = e.prot && (s == 5);
         wr_sel_i = 1'b0; wr_addr_i = 8'd0; wr_data_i = 8'hFF;
         chk("start", s, 32'(start_o), 32'(s == 1));
         chk("in", s, 32'(in_o), (s >= 2 && s <= 17) ? 32'(inm[s-2]) : 32'd0);
         chk("w", s, 32'(w_o), (s >= e.w0 && s < e.w0 + 16) ? 32'(wm[s-e.w0]) : 32'd0);
         chk("pixel_finish", s, 32'(pixel_finish_o), 32'(s == e.dn));
         chk("done", s, 32'(done_o), 32'(s == e.dn));
         chk("picture_finish", s, 32'(picture_finish_o), 32'(pic && s == e.dn));
         chk("busy", s, 32'(busy_o), 32'(s <= e.dn));
         if (s == e.dn + 1) chk("pixel_cnt", s, 32'(pixel_cnt_o), 32'((pix_m + 1) % 4));
         tick;
      end
      loadin_finish_i = 1'b0; cal_finish_i = 1'b0; go_i = 1'b0; wr_en_i = 1'b0;
      pix_m = (pix_m + 1) % 4;
      $display("pixel %0d: lf@%0d cf@%0d done@%0d pixel_cnt=%0d", k, e.lf, e.cf, e.dn, pixel_cnt_o);
   endtask

   task automatic check_idle(input string name);
      chk({name, ".busy"}, 0, 32'(busy_o), 32'd0);
      chk({name, ".start"}, 0, 32'(start_o), 32'd0);
      chk({name, ".in"}, 0, 32'(in_o), 32'd0);
      chk({name, ".w"}, 0, 32'(w_o), 32'd0);
      chk({name, ".done"}, 0, 32'(done_o), 32'd0);
      chk({name, ".pixel_finish"}, 0, 32'(pixel_finish_o), 32'd0);
      chk({name, ".picture_finish"}, 0, 32'(picture_finish_o), 32'd0);
      chk({name, ".pixel_cnt"}, 0, 32'(pixel_cnt_o), 32'(pix_m));
   endtask

   initial begin
      tbl[0] = '{18, 40,  20, 42,  1'b0, 1'b0};  // basic pixel
      tbl[1] = '{10, 40,  18, 42,  1'b0, 1'b0};  // early loadin_finish: no WAIT_IN
      tbl[2] = '{17, 30,  19, 35,  1'b0, 1'b0};  // loadin on last in edge: one WAIT_IN cycle
      tbl[3] = '{ 5,  6,  18, 34,  1'b0, 1'b0};  // both early: minimum latency, picture end
      tbl[4] = '{18, 25,  20, 36,  1'b1, 1'b0};  // go + write mid-stream ignored
      tbl[5] = '{18, 150, 20, 152, 1'b0, 1'b1};  // cal stall; write coincident with go

      errs = 0; checks = 0; pix_m = 0;
      rst_i = 1'b1; go_i = 1'b0; wr_en_i = 1'b0; wr_sel_i = 1'b0;
      wr_addr_i = '0; wr_data_i = '0; loadin_finish_i = 1'b0; cal_finish_i = 1'b0;
      tick; tick;
      check_idle("reset");
      rst_i = 1'b0;

      for (int i = 0; i < 16; i++) begin
         inm[i] = 8'(8'h10 * ((i % 4) + 1));
         wm[i]  = 8'h10;
      end
      wm[5] = 8'h00; wm[10] = 8'h00; wm[13] = 8'h00; wm[14] = 8'h00;
      load_all;
      run_pixel(0);

      for (int i = 0; i < 16; i++) begin
         inm[i] = 8'(i * 7 + 3);
         wm[i]  = 8'(200 - i * 9);
      end
      load_all;
      for (int k = 1; k < 5; k++) run_pixel(k);

      // out-of-range writes must not alias onto low addresses
      wr(1'b0, 8'd16, 8'hFF);
      wr(1'b1, 8'd16, 8'hFF);
      wr(1'b0, 8'd255, 8'hFF);
      run_pixel(5);

      // reset held two cycles in the middle of SEND_IN
      go_i = 1'b1; tick; go_i = 1'b0;
      for (int i = 0; i < 8; i++) tick;
      rst_i = 1'b1; tick; tick; rst_i = 1'b0;
      pix_m = 0;
      check_idle("midreset");
      tick;
      check_idle("midreset+1");
      $display("mid-stream reset: busy=%0d pixel_cnt=%0d", busy_o, pixel_cnt_o);

      // go coincident with rst: reset wins
      go_i = 1'b1; rst_i = 1'b1; tick; go_i = 1'b0; rst_i = 1'b0;
      check_idle("gorst");
      tick;
      check_idle("gorst+1");
      $display("go with rst: busy=%0d start=%0d", busy_o, start_o);

      run_pixel(0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
